uart_mat_load_ctrl: RTL and testbench

Sequencing controller for matrix ingest in the UART test path. Assembles the UART receiver's byte stream into 32-bit words, decodes the leading dimension header, and issues row-major write commands (address + data) into the matrix buffer. Signals completion or a framing/size error to the downstream vector datapath. It owns the element counters and write-address generation that the matrix storage itself does not.

---
 rtl/uart_mat_load_ctrl_if.sv | 21 ++
 rtl/uart_mat_load_ctrl.sv | 137 +++++++++++++
 tb/tb_uart_mat_load_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mat_load_ctrl_if.sv
// Byte-in / write-out bus of the matrix load controller: UART receive strobe
// and the row-major write port into the matrix buffer.
interface uart_mat_load_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output rx_data, rx_valid,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  rx_data, rx_valid,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/uart_mat_load_ctrl.sv
// Matrix ingest sequencer: packs UART bytes into little-endian words, decodes
// the rows/cols header and issues row-major writes into the matrix buffer.
module uart_mat_load_ctrl #(
  parameter int MAX_ROWS       = 16,
  parameter int MAX_COLS       = 16,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rstn,
  uart_mat_load_ctrl_if.slave  bus,
  input  logic                 start,
  output logic [15:0]          num_rows,
  output logic [15:0]          num_cols,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]   MR      = 16'(MAX_ROWS);
  localparam logic [15:0]   MC      = 16'(MAX_COLS);

  typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_t;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [23:0]       sr;
  logic [TW-1:0]     tcnt;
  logic [15:0]       row;
  logic [15:0]       col;
  logic [ADDR_W-1:0] row_base;
  logic [15:0]       hdr_rows;
  logic [15:0]       hdr_cols;
  logic              hdr_bad;

  // The fourth byte completes the word directly from rx_data; sr holds the first three.
  always_comb begin
    hdr_rows = sr[15:0];
    hdr_cols = {bus.rx_data, sr[23:16]};
    hdr_bad  = (hdr_rows == '0) || (hdr_cols == '0) || (hdr_rows > MR) || (hdr_cols > MC);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      sr          <= '0;
      tcnt        <= '0;
      row         <= '0;
      col         <= '0;
      row_base    <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      num_rows    <= '0;
      num_cols    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (start) begin
            state    <= HDR;
            busy     <= 1'b1;
            err      <= 1'b0;
            err_code <= '0;
            byte_cnt <= '0;
            tcnt     <= '0;
            row      <= '0;
            col      <= '0;
            row_base <= '0;
            num_rows <= '0;
            num_cols <= '0;
          end
        end
        HDR, DATA: begin
          if (bus.rx_valid) begin
            tcnt <= '0;
            if (byte_cnt != 2'd3) begin
              sr       <= {bus.rx_data, sr[23:8]};
              byte_cnt <= byte_cnt + 2'd1;
            end else begin
              byte_cnt <= '0;
              if (state == HDR) begin
                if (hdr_bad) begin
                  state    <= ERR;
                  busy     <= 1'b0;
                  err      <= 1'b1;
                  err_code <= 2'd1;
                end else begin
                  state    <= DATA;
                  num_rows <= hdr_rows;
                  num_cols <= hdr_cols;
                end
              end else begin
                bus.wr_en   <= 1'b1;
                bus.wr_addr <= row_base + ADDR_W'(col);
                bus.wr_data <= {bus.rx_data, sr};
                if (col == num_cols - 16'd1) begin
                  col      <= '0;
                  row      <= row + 16'd1;
                  row_base <= row_base + ADDR_W'(MAX_COLS);
                  // busy drops one cycle later, together with the done pulse
                  if (row == num_rows - 16'd1) state <= DONE;
                end else begin
                  col <= col + 16'd1;
                end
              end
            end
          end else if (tcnt == T_LAST) begin
            state    <= ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= 2'd2;
            byte_cnt <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mat_load_ctrl.sv
// Self-checking bench for uart_mat_load_ctrl: scoreboard of expected writes
// plus per-scenario checks of status outputs and timing.
module tb_uart_mat_load_ctrl;

  localparam int ADDR_W = 8;
  localparam int TOUT   = 20;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_rows, num_cols;
  logic        busy, done, err;
  logic [1:0]  err_code;

  uart_mat_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  uart_mat_load_ctrl #(
    .MAX_ROWS(16), .MAX_COLS(16), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .start(start),
    .num_rows(num_rows), .num_cols(num_cols), .busy(busy), .done(done),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;

  // Scoreboard: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bus.wr_en === 1'b1) begin
      exp_t e;
      wr_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%08h, none expected", bus.wr_addr, bus.wr_data);
      end else begin
        e = q.pop_front();
        if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%08h, expected addr=%0d data=%08h",
                   bus.wr_addr, bus.wr_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int unsigned i = 0; i < 4; i++) begin
      logic [31:0] t;
      t = w >> (8 * i);
      send_byte(t[7:0]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    q.delete();
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: %0d outstanding, expected 0", name, q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== '0 || bus.wr_data !== '0 || num_rows !== '0 ||
        num_cols !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || err_code !== '0) begin
      errors++;
      $display("FAIL reset_outputs: wr_en=%b addr=%0d data=%h rows=%0d cols=%0d busy=%b done=%b err=%b code=%0d, expected all 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, num_rows, num_cols, busy, done, err, err_code);
    end
  endtask

  // Loads an r x c matrix with consecutive-pattern data and checks completion timing.
  task automatic load_matrix(input string name, input int unsigned r, input int unsigned c,
                             input logic rand_data);
    int w0, d0;
    w0 = wr_cnt;
    d0 = done_cnt;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_after_start: busy=%b, expected 1", name, busy);
    end
    send_word({16'(c), 16'(r)});
    for (int unsigned i = 0; i < r; i++)
      for (int unsigned j = 0; j < c; j++) begin
        exp_t e;
        e.addr = ADDR_W'(i * 16 + j);
        e.data = rand_data ? $urandom : 32'h11111111 * (i * c + j + 1);
        q.push_back(e);
        send_word(e.data);
      end
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_last_write_cycle: done=%b busy=%b, expected done=0 busy=1", name, done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b err=%b, expected 1 0 0", name, done, busy, err);
    end
    @(negedge clk);
    checks++;
    if (num_rows !== 16'(r) || num_cols !== 16'(c)) begin
      errors++;
      $display("FAIL %s_dims: rows=%0d cols=%0d, expected %0d %0d", name, num_rows, num_cols, r, c);
    end
    checks++;
    if (wr_cnt - w0 != int'(r * c) || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL %s_counts: writes=%0d dones=%0d, expected %0d 1", name, wr_cnt - w0, done_cnt - d0, r * c);
    end
    check_queue_empty(name);
  endtask

  task automatic test_load_2x3();
    do_reset();
    load_matrix("load2x3", 2, 3, 1'b0);
  endtask

  task automatic test_max_size();
    do_reset();
    load_matrix("max16x16", 16, 16, 1'b1);
  endtask

  task automatic bad_header(input string name, input logic [31:0] hdr);
    int w0;
    w0 = wr_cnt;
    pulse_start();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL %s_err_cleared: err=%b, expected 0", name, err);
    end
    send_word(hdr);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_err: err=%b code=%0d busy=%b, expected 1 1 0", name, err, err_code, busy);
    end
    send_word(32'hDEADBEEF);
    checks++;
    if (wr_cnt != w0 || err !== 1'b1 || err_code !== 2'd1) begin
      errors++;
      $display("FAIL %s_held: writes=%0d err=%b code=%0d, expected 0 1 1", name, wr_cnt - w0, err, err_code);
    end
  endtask

  task automatic test_bad_header();
    do_reset();
    bad_header("rows0", 32'h00040000);
    bad_header("rows17", 32'h00010011);
    pulse_start();
    checks++;
    if (err !== 1'b0 || err_code !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bad_hdr_restart: err=%b code=%0d busy=%b, expected 0 0 1", err, err_code, busy);
    end
  endtask

  task automatic test_timeout();
    int   k, w0, d0;
    exp_t e;
    do_reset();
    w0 = wr_cnt;
    d0 = done_cnt;
    pulse_start();
    send_word(32'h00020001);
    e.addr = '0;
    e.data = 32'hA5C3_0F96;
    q.push_back(e);
    send_word(e.data);
    send_byte(8'h12);
    send_byte(8'h34);
    k = 1;
    while (err !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != TOUT + 1) begin
      errors++;
      $display("FAIL timeout_latency: err after %0d cycles, expected %0d", k, TOUT + 1);
    end
    checks++;
    if (err_code !== 2'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_code: code=%0d busy=%b, expected 2 0", err_code, busy);
    end
    checks++;
    if (wr_cnt - w0 != 1 || done_cnt != d0) begin
      errors++;
      $display("FAIL timeout_counts: writes=%0d dones=%0d, expected 1 0", wr_cnt - w0, done_cnt - d0);
    end
    check_queue_empty("timeout");
  endtask

  task automatic test_reset_midload();
    int w0;
    do_reset();
    pulse_start();
    send_word(32'h00040002);
    for (int unsigned i = 0; i < 5; i++) begin
      exp_t e;
      e.addr = ADDR_W'((i / 4) * 16 + (i % 4));
      e.data = 32'hC0DE0000 + i;
      q.push_back(e);
      send_word(e.data);
    end
    send_byte(8'h77);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check_queue_empty("midload_pre");
    checks++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== '0 || bus.wr_data !== '0 || num_rows !== '0 ||
        num_cols !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || err_code !== '0) begin
      errors++;
      $display("FAIL midload_reset_outputs: wr_en=%b addr=%0d rows=%0d cols=%0d busy=%b err=%b, expected all 0",
               bus.wr_en, bus.wr_addr, num_rows, num_cols, busy, err);
    end
    w0 = wr_cnt;
    for (int unsigned i = 0; i < 3; i++) send_word(32'h01020304 * (i + 1));
    checks++;
    if (wr_cnt != w0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midload_idle_bytes: writes=%0d busy=%b, expected 0 0", wr_cnt - w0, busy);
    end
    load_matrix("midload_fresh", 2, 4, 1'b1);
  endtask

  task automatic test_start_ignored();
    int d0;
    exp_t e;
    do_reset();
    d0 = done_cnt;
    send_word(32'h00020002);
    // Byte coincident with the arming start must be dropped.
    start = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    bus.rx_valid = 1'b0;
    send_word(32'h00020002);
    for (int unsigned i = 0; i < 4; i++) begin
      e.addr = ADDR_W'((i / 2) * 16 + (i % 2));
      e.data = 32'h5A000000 | i;
      q.push_back(e);
      send_word(e.data);
      if (i == 1) begin
        pulse_start();
        send_byte(e.data[7:0] ^ 8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        e.data = 32'hCCBBAA00 | 32'(e.data[7:0] ^ 8'h01);
        e.addr = ADDR_W'(16);
        q.push_back(e);
        i = 2;
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
          errors++;
          $display("FAIL start_in_data: busy=%b err=%b, expected 1 0", busy, err);
        end
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || num_rows !== 16'd2 || num_cols !== 16'd2) begin
      errors++;
      $display("FAIL start_ignored_done: dones=%0d rows=%0d cols=%0d, expected 1 2 2",
               done_cnt - d0, num_rows, num_cols);
    end
    check_queue_empty("start_ignored");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    @(negedge clk);
    test_reset();
    test_load_2x3();
    test_max_size();
    test_bad_header();
    test_timeout();
    test_reset_midload();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
